lc3b_decode_stage: RTL and testbench
====================================

Name: lc3b_decode_stage

Overview:
- ID stage of the LC-3B pipeline: accepts one fetched instruction per cycle, decodes it into an LC_3B_control_word plus register/immediate fields, and registers the result into the ID/EX pipeline register.
- Detects load-use hazards against the instruction currently held in ID/EX and inserts one bubble.
- Honours a flush from the branch-resolution logic.
- Sits between the fetch stage (upstream) and the execute stage (downstream).

Parameters:
- NOP_IR, 16'h0000, instruction word loaded into ex_ir on reset, flush or bubble (BR with nzp=000).

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  ID accepts the instruction this cycle
- if_pc  in  16  PC+2 of the fetched instruction
- if_ir  in  16  instruction word
- flush  in  1  discard the fetched and the ID/EX contents
- sr1_addr  out  3  register-file read address A (combinational)
- sr2_addr  out  3  register-file read address B (combinational)
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_ready  in  1  execute stage consumes ID/EX this cycle
- ex_cw  out  $bits(LC_3B_control_word)  registered control word; ex_cw.PC = if_pc
- ex_ir  out  16  registered instruction word, for immediates and offsets
- ex_dr  out  3  registered destination register

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - During reset: ex_valid=0, ex_cw=0, ex_ir=NOP_IR, ex_dr=0.
  - Reset asserted mid-stall clears everything; the first valid instruction after reset is accepted on the first rising edge with rst_n=1.
- Field extraction (combinational, from if_ir):
  - Default fields: opcode=ir[15:12], DR=ir[11:9], SR1=ir[8:6], SR2=ir[2:0].
  - sr1_addr = SR1, except JMP/JSRR, which also use ir[8:6].
  - sr2_addr = ir[11:9] for STR/STB/STI (storemux_select=1); otherwise ir[2:0].
- Decode (combinational, registered into ex_cw); all unlisted fields are 0:
  - ADD/AND: OPAlu add/and; REQSR1=1; REQSR2=~ir[5]; sr2mux_select=ir[5]; registerload=1; LDC_CC=1; dr_REQ=1.
  - NOT: Alu_not; REQSR1=1; registerload=1; LDC_CC=1.
  - SHF: ir[4]=0 gives shiftleft; ir[4]=1 with ir[5]=0 gives shiftrile; ir[4]=1 with ir[5]=1 gives signedshiftright. REQSR1=1; registerload=1; LDC_CC=1.
  - LDR/LDB: DCacheR=1; DCache_enable=1; REQSR1=1; registerload=1; LDC_CC=1; wbmux_select=2'b01; OPLDB set for LDB.
  - LDI: as LDR, plus OP_LDI=1.
  - STR/STB/STI: write_DCache=1; DCache_enable=1; REQSR1=1; REQSR2=1; OPSTB or OP_STI set as applicable.
  - BR: OPBR=1; addr2mux_select=2'b10 (offset9).
  - JMP: OPJMP=1; REQSR1=1.
  - JSR: OPJSR=1; Destination_mux_select=1 (R7); registerload=1; ir[11]=1 gives addr2mux_select=2'b11 (offset11); otherwise REQSR1=1.
  - LEA: addr2mux_select=2'b10; registerload=1; LDC_CC=1; wbmux_select=2'b10.
  - TRAP: OPTRAP=1; Destination_mux_select=1; registerload=1.
  - RTI: all-zero control word (no-op).
- ex_dr = 3'd7 when Destination_mux_select=1; otherwise ir[11:9].
- Hazard (load-use):
  - hazard = if_valid & ex_valid & ex_cw.DCacheR & ex_cw.registerload & ((REQSR1 & sr1_addr==ex_dr) | (REQSR2 & sr2_addr==ex_dr)).
  - Here REQSR1/REQSR2 are the incoming decode's values.
- Handshake:
  - advance = ~ex_valid | ex_ready.
  - if_ready = advance & ~hazard, or 1 when flush=1 (the fetched word is consumed and dropped).
- Register update on posedge clk, first match wins:
  - flush: ex_valid<=0, ex_ir<=NOP_IR, ex_cw<=0.
  - advance & hazard: bubble; ex_valid<=0, ex_ir<=NOP_IR, ex_cw<=0.
  - advance & if_valid: load the decode; ex_valid<=1.
  - advance & ~if_valid: ex_valid<=0.
  - ~advance: hold all registers.
- Latency: one cycle from if_valid&if_ready to ex_valid.
- Throughput: one instruction per cycle without hazards.
- A load-use pair costs exactly one bubble.
- flush and hazard in the same cycle resolve as flush.

Optional Feature:
- Macro: LC3B_ILLEGAL_OP_EN.
- Defined:
  - RTI decodes as TRAP to vector 0x00: OPTRAP=1; ex_ir<={8'hF0,8'h00}.
  - A 1-cycle output illegal_op (extra port, reset 0) pulses on acceptance.
- Undefined:
  - RTI is a no-op.
  - The illegal_op port is absent.

Test Plan:
- Reset: drive rst_n=0 mid-stream -> ex_valid=0, ex_ir=16'h0000, ex_cw=0 immediately; accepting resumes on the first edge after release.
- ADD R1,R2,#3 (16'h12A3), ex_ready=1 -> next cycle ex_valid=1, OPAlu=Alu_add, sr2mux_select=1, REQSR2=0, ex_dr=1, registerload=1.
- LDR R3,R4,#0 (16'h6700) then ADD R5,R3,R2 (16'h1AC2) -> the cycle after the LDR registers shows if_ready=0 and hazard=1; the next ID/EX is a bubble (ex_valid=0); ADD enters one cycle later.
- Back-pressure: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0 and ex_* stable for 3 cycles; the instruction is accepted on the cycle ex_ready rises.
- flush=1 together with if_valid=1 and a hazard -> if_ready=1; next cycle ex_valid=0, ex_ir=NOP_IR.
- STR R6,R1,#2 (16'h7C42) -> sr2_addr=6, storemux_select=1, write_DCache=1, REQSR1=REQSR2=1, registerload=0.

Source files
------------

// File: rtl/lc3b_decode_stage.sv
// LC-3B ID stage: decodes one instruction per cycle into the ID/EX register with load-use bubbling and flush.
// Optional build macro LC3B_ILLEGAL_OP_EN: RTI becomes TRAP x00 and an illegal_op pulse is added.
package lc3b_pkg;

  typedef enum logic [2:0] {
    Alu_add,
    Alu_and,
    Alu_not,
    shiftleft,
    shiftrile,
    signedshiftright
  } alu_ops;

  typedef enum logic [3:0] {
    op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;

  typedef struct packed {
    logic [15:0] PC;
    alu_ops      OPAlu;
    logic        REQSR1;
    logic        REQSR2;
    logic        sr2mux_select;
    logic        registerload;
    logic        LDC_CC;
    logic        dr_REQ;
    logic        DCacheR;
    logic        DCache_enable;
    logic        write_DCache;
    logic        storemux_select;
    logic [1:0]  wbmux_select;
    logic        OPLDB;
    logic        OP_LDI;
    logic        OPSTB;
    logic        OP_STI;
    logic        OPBR;
    logic        OPJMP;
    logic        OPJSR;
    logic        OPTRAP;
    logic [1:0]  addr2mux_select;
    logic        Destination_mux_select;
  } LC_3B_control_word;

endpackage

module lc3b_decode_stage
  import lc3b_pkg::*;
#(
  parameter logic [15:0] NOP_IR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [15:0]       if_pc,
  input  logic [15:0]       if_ir,
  input  logic              flush,
  output logic [2:0]        sr1_addr,
  output logic [2:0]        sr2_addr,
  output logic              ex_valid,
  input  logic              ex_ready,
  output LC_3B_control_word ex_cw,
  output logic [15:0]       ex_ir,
  output logic [2:0]        ex_dr
`ifdef LC3B_ILLEGAL_OP_EN
  ,
  output logic              illegal_op
`endif
);

  LC_3B_control_word w_cw;
  lc3b_opcode        w_opcode;
  logic [15:0]       w_ir_out;
  logic [2:0]        w_dr;
  logic              w_hazard;
  logic              w_advance;

  LC_3B_control_word r_ex_cw;
  logic              r_ex_valid;
  logic [15:0]       r_ex_ir;
  logic [2:0]        r_ex_dr;

  assign w_opcode = lc3b_opcode'(if_ir[15:12]);

  always_comb begin
    w_cw     = '0;
    w_cw.PC  = if_pc;
    w_ir_out = if_ir;
    case (w_opcode)
      op_add, op_and: begin
        w_cw.OPAlu         = (w_opcode == op_and) ? Alu_and : Alu_add;
        w_cw.REQSR1        = 1'b1;
        w_cw.REQSR2        = ~if_ir[5];
        w_cw.sr2mux_select = if_ir[5];
        w_cw.registerload  = 1'b1;
        w_cw.LDC_CC        = 1'b1;
        w_cw.dr_REQ        = 1'b1;
      end
      op_not: begin
        w_cw.OPAlu        = Alu_not;
        w_cw.REQSR1       = 1'b1;
        w_cw.registerload = 1'b1;
        w_cw.LDC_CC       = 1'b1;
      end
      op_shf: begin
        if (!if_ir[4])     w_cw.OPAlu = shiftleft;
        else if (!if_ir[5]) w_cw.OPAlu = shiftrile;
        else               w_cw.OPAlu = signedshiftright;
        w_cw.REQSR1       = 1'b1;
        w_cw.registerload = 1'b1;
        w_cw.LDC_CC       = 1'b1;
      end
      op_ldr, op_ldb, op_ldi: begin
        w_cw.DCacheR       = 1'b1;
        w_cw.DCache_enable = 1'b1;
        w_cw.REQSR1        = 1'b1;
        w_cw.registerload  = 1'b1;
        w_cw.LDC_CC        = 1'b1;
        w_cw.wbmux_select  = 2'b01;
        w_cw.OPLDB         = (w_opcode == op_ldb);
        w_cw.OP_LDI        = (w_opcode == op_ldi);
      end
      op_str, op_stb, op_sti: begin
        w_cw.write_DCache    = 1'b1;
        w_cw.DCache_enable   = 1'b1;
        w_cw.REQSR1          = 1'b1;
        w_cw.REQSR2          = 1'b1;
        w_cw.storemux_select = 1'b1;
        w_cw.OPSTB           = (w_opcode == op_stb);
        w_cw.OP_STI          = (w_opcode == op_sti);
      end
      op_br: begin
        w_cw.OPBR            = 1'b1;
        w_cw.addr2mux_select = 2'b10;
      end
      op_jmp: begin
        w_cw.OPJMP  = 1'b1;
        w_cw.REQSR1 = 1'b1;
      end
      op_jsr: begin
        w_cw.OPJSR                  = 1'b1;
        w_cw.Destination_mux_select = 1'b1;
        w_cw.registerload           = 1'b1;
        if (if_ir[11]) w_cw.addr2mux_select = 2'b11;
        else           w_cw.REQSR1          = 1'b1;
      end
      op_lea: begin
        w_cw.addr2mux_select = 2'b10;
        w_cw.registerload    = 1'b1;
        w_cw.LDC_CC          = 1'b1;
        w_cw.wbmux_select    = 2'b10;
      end
      op_trap: begin
        w_cw.OPTRAP                 = 1'b1;
        w_cw.Destination_mux_select = 1'b1;
        w_cw.registerload           = 1'b1;
      end
      op_rti: begin
`ifdef LC3B_ILLEGAL_OP_EN
        w_cw.OPTRAP = 1'b1;
        w_ir_out    = {8'hF0, 8'h00};
`endif
      end
      default: ;
    endcase
  end

  assign sr1_addr = if_ir[8:6];
  assign sr2_addr = w_cw.storemux_select ? if_ir[11:9] : if_ir[2:0];
  assign w_dr     = w_cw.Destination_mux_select ? 3'd7 : if_ir[11:9];

  // Only a load still sitting in ID/EX can stall; its data is not forwardable this cycle.
  assign w_hazard = if_valid & r_ex_valid & r_ex_cw.DCacheR & r_ex_cw.registerload &
                    ((w_cw.REQSR1 & (sr1_addr == r_ex_dr)) |
                     (w_cw.REQSR2 & (sr2_addr == r_ex_dr)));

  assign w_advance = ~r_ex_valid | ex_ready;
  assign if_ready  = flush | (w_advance & ~w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_cw    <= '0;
      r_ex_ir    <= NOP_IR;
      r_ex_dr    <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
      r_ex_cw    <= '0;
      r_ex_ir    <= NOP_IR;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_ex_valid <= 1'b0;
        r_ex_cw    <= '0;
        r_ex_ir    <= NOP_IR;
      end else if (if_valid) begin
        r_ex_valid <= 1'b1;
        r_ex_cw    <= w_cw;
        r_ex_ir    <= w_ir_out;
        r_ex_dr    <= w_dr;
      end else begin
        r_ex_valid <= 1'b0;
      end
    end
  end

`ifdef LC3B_ILLEGAL_OP_EN
  logic r_illegal_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal_op <= 1'b0;
    else        r_illegal_op <= ~flush & w_advance & ~w_hazard & if_valid & (w_opcode == op_rti);
  end

  assign illegal_op = r_illegal_op;
`endif

  assign ex_valid = r_ex_valid;
  assign ex_cw    = r_ex_cw;
  assign ex_ir    = r_ex_ir;
  assign ex_dr    = r_ex_dr;

endmodule

// File: tb/tb_lc3b_decode_stage.sv
// Bench for lc3b_decode_stage: hand-derived decode table, directed pipeline corner cases, random stream vs reference model.
module tb_lc3b_decode_stage;
  import lc3b_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_valid, if_ready, flush, ex_valid, ex_ready;
  logic [15:0]       if_pc, if_ir, ex_ir;
  logic [2:0]        sr1_addr, sr2_addr, ex_dr;
  LC_3B_control_word ex_cw;
`ifdef LC3B_ILLEGAL_OP_EN
  logic              illegal_op;
`endif

  lc3b_decode_stage #(.NOP_IR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_ir(if_ir), .flush(flush), .sr1_addr(sr1_addr),
    .sr2_addr(sr2_addr), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_cw(ex_cw), .ex_ir(ex_ir), .ex_dr(ex_dr)
`ifdef LC3B_ILLEGAL_OP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, organised by instruction class rather than per opcode.
  function automatic LC_3B_control_word ref_decode(input logic [15:0] ir, input logic [15:0] pc);
    LC_3B_control_word c;
    logic [3:0] op = ir[15:12];
    bit is_ld  = (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
    bit is_st  = (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
    bit is_rr  = (op == 4'h1) || (op == 4'h5);
    bit is_alu = is_rr || (op == 4'h9) || (op == 4'hD);
    bit is_lnk = (op == 4'h4) || (op == 4'hF);
    bit is_lea = (op == 4'hE);
    c = '0;
    c.PC                     = pc;
    c.registerload           = is_alu || is_ld || is_lnk || is_lea;
    c.LDC_CC                 = is_alu || is_ld || is_lea;
    c.REQSR1                 = is_alu || is_ld || is_st || (op == 4'hC) || (op == 4'h4 && !ir[11]);
    c.REQSR2                 = is_st || (is_rr && !ir[5]);
    c.sr2mux_select          = is_rr && ir[5];
    c.dr_REQ                 = is_rr;
    c.DCacheR                = is_ld;
    c.DCache_enable          = is_ld || is_st;
    c.write_DCache           = is_st;
    c.storemux_select        = is_st;
    c.wbmux_select           = is_ld ? 2'b01 : (is_lea ? 2'b10 : 2'b00);
    c.OPLDB                  = (op == 4'h2);
    c.OP_LDI                 = (op == 4'hA);
    c.OPSTB                  = (op == 4'h3);
    c.OP_STI                 = (op == 4'hB);
    c.OPBR                   = (op == 4'h0);
    c.OPJMP                  = (op == 4'hC);
    c.OPJSR                  = (op == 4'h4);
    c.OPTRAP                 = (op == 4'hF);
`ifdef LC3B_ILLEGAL_OP_EN
    if (op == 4'h8) c.OPTRAP = 1'b1;
`endif
    c.Destination_mux_select = is_lnk;
    if (op == 4'h0 || is_lea) c.addr2mux_select = 2'b10;
    else if (op == 4'h4 && ir[11]) c.addr2mux_select = 2'b11;
    case (op)
      4'h5: c.OPAlu = Alu_and;
      4'h9: c.OPAlu = Alu_not;
      4'hD: c.OPAlu = !ir[4] ? shiftleft : (ir[5] ? signedshiftright : shiftrile);
      default: c.OPAlu = Alu_add;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] ref_ir(input logic [15:0] ir);
`ifdef LC3B_ILLEGAL_OP_EN
    if (ir[15:12] == 4'h8) return 16'hF000;
`endif
    return ir;
  endfunction

  function automatic logic [2:0] ref_sr2(input logic [15:0] ir);
    logic [3:0] op = ir[15:12];
    return (op == 4'h3 || op == 4'h7 || op == 4'hB) ? ir[11:9] : ir[2:0];
  endfunction

  // Model of the ID/EX register contents.
  logic              m_valid;
  LC_3B_control_word m_cw;
  logic [15:0]       m_ir;
  logic [2:0]        m_dr;
  logic              last_rdy;
  logic [2:0]        last_sr2;

  task automatic model_reset();
    m_valid = 1'b0; m_cw = '0; m_ir = 16'h0000; m_dr = 3'd0;
  endtask

  task automatic cycle();
    LC_3B_control_word d;
    logic [2:0] s2, ddr;
    logic hz, adv, rdy;
`ifdef LC3B_ILLEGAL_OP_EN
    logic exp_ill;
`endif
    @(negedge clk);
    d   = ref_decode(if_ir, if_pc);
    s2  = ref_sr2(if_ir);
    ddr = d.Destination_mux_select ? 3'd7 : if_ir[11:9];
    hz  = if_valid && m_valid && m_cw.DCacheR && m_cw.registerload &&
          ((d.REQSR1 && if_ir[8:6] == m_dr) || (d.REQSR2 && s2 == m_dr));
    adv = !m_valid || ex_ready;
    rdy = flush || (adv && !hz);
    last_rdy = if_ready;
    last_sr2 = sr2_addr;
    chk("if_ready", 64'(if_ready), 64'(rdy));
    chk("sr1_addr", 64'(sr1_addr), 64'(if_ir[8:6]));
    chk("sr2_addr", 64'(sr2_addr), 64'(s2));
`ifdef LC3B_ILLEGAL_OP_EN
    exp_ill = !flush && adv && !hz && if_valid && (if_ir[15:12] == 4'h8);
`endif
    @(posedge clk);
    #1;
    if (flush || (adv && hz)) begin
      m_valid = 1'b0; m_cw = '0; m_ir = 16'h0000;
    end else if (adv && if_valid) begin
      m_valid = 1'b1; m_cw = d; m_ir = ref_ir(if_ir); m_dr = ddr;
    end else if (adv) begin
      m_valid = 1'b0;
    end
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_cw", 64'(ex_cw), 64'(m_cw));
    chk("ex_ir", 64'(ex_ir), 64'(m_ir));
    if (m_valid) chk("ex_dr", 64'(ex_dr), 64'(m_dr));
`ifdef LC3B_ILLEGAL_OP_EN
    chk("illegal_op", 64'(illegal_op), 64'(exp_ill));
`endif
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic        rl, req1, req2, dcr, wd, s2mux;
    logic [1:0]  a2;
    alu_ops      alu;
  } vec_t;

  vec_t tbl[12];

  initial begin
    //            ir        sr2   dr    rl    req1  req2  dcr   wd    s2mux a2     alu
    tbl[0]  = '{16'h12A3, 3'd3, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, Alu_add};
    tbl[1]  = '{16'h6700, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, Alu_add};
    tbl[2]  = '{16'h7C42, 3'd6, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, Alu_add};
    tbl[3]  = '{16'h1AC2, 3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, Alu_add};
    tbl[4]  = '{16'h0E05, 3'd5, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, Alu_add};
    tbl[5]  = '{16'h4803, 3'd3, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, Alu_add};
    tbl[6]  = '{16'h4080, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, Alu_add};
    tbl[7]  = '{16'hF025, 3'd5, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, Alu_add};
    tbl[8]  = '{16'hE805, 3'd5, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, Alu_add};
    tbl[9]  = '{16'h94FF, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, Alu_not};
    tbl[10] = '{16'hB1C1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, Alu_add};
    tbl[11] = '{16'hD2B3, 3'd3, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, signedshiftright};

    rst_n = 1'b0; if_valid = 1'b0; if_pc = 16'h0; if_ir = 16'h0; flush = 1'b0; ex_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_cw", 64'(ex_cw), 64'd0);
    chk("rst_ir", 64'(ex_ir), 64'h0000);
    chk("rst_dr", 64'(ex_dr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decode table: each instruction presented alone, then one idle cycle.
    for (int i = 0; i < 12; i++) begin
      if_valid = 1'b1; if_ir = tbl[i].ir; if_pc = 16'h3000 + 16'(2 * i);
      cycle();
      chk("tbl_sr2", 64'(last_sr2), 64'(tbl[i].sr2));
      chk("tbl_valid", 64'(ex_valid), 64'd1);
      chk("tbl_dr", 64'(ex_dr), 64'(tbl[i].dr));
      chk("tbl_rl", 64'(ex_cw.registerload), 64'(tbl[i].rl));
      chk("tbl_req1", 64'(ex_cw.REQSR1), 64'(tbl[i].req1));
      chk("tbl_req2", 64'(ex_cw.REQSR2), 64'(tbl[i].req2));
      chk("tbl_dcr", 64'(ex_cw.DCacheR), 64'(tbl[i].dcr));
      chk("tbl_wd", 64'(ex_cw.write_DCache), 64'(tbl[i].wd));
      chk("tbl_s2mux", 64'(ex_cw.sr2mux_select), 64'(tbl[i].s2mux));
      chk("tbl_a2", 64'(ex_cw.addr2mux_select), 64'(tbl[i].a2));
      chk("tbl_alu", 64'(ex_cw.OPAlu), 64'(tbl[i].alu));
      chk("tbl_pc", 64'(ex_cw.PC), 64'(16'h3000 + 16'(2 * i)));
      if_valid = 1'b0;
      cycle();
    end

    // Load-use: LDR R3 then ADD using R3 costs one bubble.
    if_valid = 1'b1; if_ir = 16'h6700; cycle();
    if_ir = 16'h1AC2; cycle();
    chk("lu_stall_rdy", 64'(last_rdy), 64'd0);
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    cycle();
    chk("lu_accept_rdy", 64'(last_rdy), 64'd1);
    chk("lu_add_ir", 64'(ex_ir), 64'h1AC2);
    if_valid = 1'b0; cycle();

    // Back-pressure for three cycles.
    if_valid = 1'b1; if_ir = 16'h12A3; cycle();
    ex_ready = 1'b0; if_ir = 16'h94FF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_rdy", 64'(last_rdy), 64'd0);
      chk("bp_hold_ir", 64'(ex_ir), 64'h12A3);
      chk("bp_hold_valid", 64'(ex_valid), 64'd1);
    end
    ex_ready = 1'b1; cycle();
    chk("bp_release_rdy", 64'(last_rdy), 64'd1);
    chk("bp_release_ir", 64'(ex_ir), 64'h94FF);

    // Flush coinciding with a load-use hazard.
    if_ir = 16'h6700; cycle();
    if_ir = 16'h1AC2; flush = 1'b1; cycle();
    chk("fl_rdy", 64'(last_rdy), 64'd1);
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_ir", 64'(ex_ir), 64'h0000);
    flush = 1'b0; if_valid = 1'b0; cycle();

    // Asynchronous reset while stalled.
    if_valid = 1'b1; if_ir = 16'h12A3; cycle();
    ex_ready = 1'b0; if_ir = 16'h94FF; cycle();
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(ex_valid), 64'd0);
    chk("ar_ir", 64'(ex_ir), 64'h0000);
    chk("ar_cw", 64'(ex_cw), 64'd0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    cycle();
    chk("ar_first_valid", 64'(ex_valid), 64'd1);
    chk("ar_first_ir", 64'(ex_ir), 64'h94FF);
    ex_ready = 1'b1;

    // Random stream, registers biased low so load-use pairs are common.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'h6;
      if ($urandom_range(0, 3) != 0) w = w & 16'hF6FB;
      if_ir    = w;
      if_pc    = 16'($urandom);
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
